// File: rtl/mem_access.sv
// MEM pipeline stage: turns EX/MEM load/store control into byte-enabled data-RAM requests,
// stalls while a request is outstanding and formats returned load data for MEM/WB.
module mem_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUResIn,
    input  logic [31:0] storeData,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  memSize,
    input  logic        memSigned,
    output logic [31:0] dataMemOut,
    output logic        memStall,
    output logic        misalign,
    output logic        busErr,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_r, state_nxt_s;
    logic [7:0]  cnt_r;
    logic [1:0]  size_r;
    logic        sgn_r;
    logic [1:0]  lane_r;
    logic        access_s, start_s, timeout_s;
    logic [1:0]  lane_s;

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   store_be = 4'b0001 << lane;
            2'b01:   store_be = lane[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] sd);
        case (size)
            2'b00:   store_wdata = {4{sd[7:0]}};
            2'b01:   store_wdata = {2{sd[15:0]}};
            default: store_wdata = sd;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [1:0] size, input logic sgn,
                                             input logic [1:0] lane, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{lane, 3'b000} +: 8];
        h = rdata[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   load_fmt = {{24{sgn & b[7]}}, b};
            2'b01:   load_fmt = {{16{sgn & h[15]}}, h};
            default: load_fmt = rdata;
        endcase
    endfunction

    assign lane_s    = ALUResIn[1:0];
    assign access_s  = memRead | memWrite;
    assign misalign  = access_s & (((memSize == 2'b01) & lane_s[0]) |
                                   (memSize[1] & (lane_s != 2'b00)));
    assign start_s   = access_s & ~misalign;
    assign timeout_s = (cnt_r == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and stall decode; DONE never stalls so MEM/WB captures the result
    always_comb begin
        state_nxt_s = state_r;
        memStall    = 1'b0;
        case (state_r)
            IDLE: begin
                memStall = start_s;
                if (start_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                memStall = 1'b1;
                if (dm_ack || timeout_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Request launch, timeout counting and load-data capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            dataMemOut <= 32'd0;
            busErr     <= 1'b0;
            dm_req     <= 1'b0;
            dm_we      <= 1'b0;
            dm_addr    <= 32'd0;
            dm_be      <= 4'd0;
            dm_wdata   <= 32'd0;
            cnt_r      <= 8'd0;
            size_r     <= 2'd0;
            sgn_r      <= 1'b0;
            lane_r     <= 2'd0;
        end else begin
            busErr <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        dm_req   <= 1'b1;
                        dm_we    <= memWrite;
                        dm_addr  <= {ALUResIn[31:2], 2'b00};
                        dm_be    <= memWrite ? store_be(memSize, lane_s) : 4'b1111;
                        dm_wdata <= store_wdata(memSize, storeData);
                        cnt_r    <= 8'd0;
                        size_r   <= memSize;
                        sgn_r    <= memSigned;
                        lane_r   <= lane_s;
                    end
                end
                BUSY: begin
                    // ack has priority over a coincident timeout
                    if (dm_ack) begin
                        dm_req <= 1'b0;
                        if (!dm_we) begin
                            dataMemOut <= load_fmt(size_r, sgn_r, lane_r, dm_rdata);
                        end
                    end else if (timeout_s) begin
                        dm_req <= 1'b0;
                        busErr <= 1'b1;
                        if (!dm_we) begin
                            dataMemOut <= 32'd0;
                        end
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                DONE: begin
                    dm_req <= 1'b0;
                end
                default: begin
                    dm_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected requests/completions,
// a negedge monitor pops and compares when dm_req rises or a stall ends.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUResIn, storeData, dataMemOut, dm_addr, dm_wdata, dm_rdata;
    logic        memRead, memWrite, memSigned, memStall, misalign, busErr;
    logic        dm_req, dm_we, dm_ack;
    logic [1:0]  memSize;
    logic [3:0]  dm_be;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wd;
    } req_t;

    typedef struct {
        logic [31:0] dout;
        logic        berr;
        int          stalls;
    } comp_t;

    req_t  req_q[$];
    comp_t comp_q[$];

    mem_access #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .ALUResIn(ALUResIn), .storeData(storeData),
        .memRead(memRead), .memWrite(memWrite), .memSize(memSize), .memSigned(memSigned),
        .dataMemOut(dataMemOut), .memStall(memStall), .misalign(misalign), .busErr(busErr),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endfunction

    // Monitor
    int   stall_cnt = 0;
    int   berr_cnt = 0;
    logic prev_stall = 1'b0;
    logic prev_req = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            stall_cnt  = 0;
            prev_stall = 1'b0;
            prev_req   = 1'b0;
        end else begin
            if (memStall) stall_cnt++;
            if (busErr) berr_cnt++;
            if (dm_req && !prev_req) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", {31'd0, dm_req}, 32'd0);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    chk("req_we", {31'd0, dm_we}, {31'd0, r.we});
                    chk("req_addr", dm_addr, r.addr);
                    chk("req_be", {28'd0, dm_be}, {28'd0, r.be});
                    if (r.chk_wd) chk("req_wdata", dm_wdata, r.wdata);
                end
            end
            if (prev_stall && !memStall) begin
                if (comp_q.size() == 0) begin
                    chk("unexpected_done", {31'd0, prev_stall}, 32'd0);
                end else begin
                    comp_t c;
                    c = comp_q.pop_front();
                    chk("done_data", dataMemOut, c.dout);
                    chk("done_buserr", {31'd0, busErr}, {31'd0, c.berr});
                    chk("done_stalls", stall_cnt, c.stalls);
                end
                stall_cnt = 0;
            end
            prev_stall = memStall;
            prev_req   = dm_req;
        end
    end

    // One access; k = ack cycle within BUSY (0 = never ack)
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] size,
                              input logic sgn, input logic [31:0] addr, input logic [31:0] sd,
                              input int k, input logic [31:0] rdata,
                              input logic [3:0] exp_be, input logic [31:0] exp_wd,
                              input logic [31:0] exp_dout, input logic exp_berr,
                              input int exp_stalls);
        bit done;
        req_q.push_back('{we: wr, addr: {addr[31:2], 2'b00}, be: exp_be, wdata: exp_wd, chk_wd: wr});
        comp_q.push_back('{dout: exp_dout, berr: exp_berr, stalls: exp_stalls});
        memRead = rd; memWrite = wr; memSize = size; memSigned = sgn;
        ALUResIn = addr; storeData = sd;
        @(posedge clk); #1;
        done = 1'b0;
        for (int i = 1; i <= 40 && !done; i++) begin
            dm_ack = (i == k); dm_rdata = rdata;
            @(posedge clk); #1;
            dm_ack = 1'b0;
            if (!memStall) done = 1'b1;
        end
        if (!done) chk("wait_done", {31'd0, memStall}, 32'd0);
        // DONE cycle: inputs still held and must not restart
        @(posedge clk); #1;
        memRead = 1'b0; memWrite = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; memRead = 1'b0; memWrite = 1'b0; memSize = 2'b00; memSigned = 1'b0;
        ALUResIn = 32'd0; storeData = 32'd0; dm_ack = 1'b0; dm_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", dataMemOut, 32'd0);
        chk("rst_ctl", {26'd0, dm_req, dm_we, busErr, memStall, misalign, 1'b0}, 32'd0);
        chk("rst_addr", dm_addr, 32'd0);
        chk("rst_be_wd", dm_wdata | {28'd0, dm_be}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // LW, ack at 3rd BUSY cycle -> 4 stalls
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0, 3, 32'hDEAD_BEEF,
                   4'b1111, 32'd0, 32'hDEAD_BEEF, 1'b0, 4);
        // LB / LBU at lane 3, LH at lane 2
        run_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'd0, 1, 32'h80FF_0000,
                   4'b1111, 32'd0, 32'hFFFF_FF80, 1'b0, 2);
        run_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'd0, 2, 32'h80FF_0000,
                   4'b1111, 32'd0, 32'h0000_0080, 1'b0, 3);
        run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'd0, 5, 32'h80FF_0000,
                   4'b1111, 32'd0, 32'hFFFF_80FF, 1'b0, 6);
        // Stores leave dataMemOut unchanged
        run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h1234_5678, 1, 32'hFFFF_FFFF,
                   4'b0010, 32'h7878_7878, 32'hFFFF_80FF, 1'b0, 2);
        run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h1234_5678, 2, 32'hFFFF_FFFF,
                   4'b1100, 32'h5678_5678, 32'hFFFF_80FF, 1'b0, 3);
        run_access(1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_0104, 32'h1234_5678, 1, 32'hFFFF_FFFF,
                   4'b1111, 32'h1234_5678, 32'hFFFF_80FF, 1'b0, 2);

        // Misaligned LW and LH: no request, no stall
        memRead = 1'b1; memSize = 2'b10; ALUResIn = 32'h0000_0102;
        #1;
        chk("mis_lw", {30'd0, misalign, memStall}, 32'd2);
        @(posedge clk); #1;
        memSize = 2'b01; ALUResIn = 32'h0000_0101;
        #1;
        chk("mis_lh", {30'd0, misalign, memStall}, 32'd2);
        @(posedge clk); #1;
        memRead = 1'b0;
        chk("mis_noreq", {31'd0, dm_req}, 32'd0);
        chk("mis_dout", dataMemOut, 32'hFFFF_80FF);

        // Timeout: 1 + 16 stall cycles, busErr, load data cleared
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'd0, 0, 32'd0,
                   4'b1111, 32'd0, 32'd0, 1'b1, 17);
        dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dm_ack = 1'b0;
        chk("stray_ack_dout", dataMemOut, 32'd0);
        chk("stray_ack_req", {31'd0, dm_req}, 32'd0);

        // Reset while BUSY
        req_q.push_back('{we: 1'b0, addr: 32'h0000_0400, be: 4'b1111, wdata: 32'd0, chk_wd: 1'b0});
        memRead = 1'b1; memSize = 2'b10; ALUResIn = 32'h0000_0400;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0; memRead = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ctl", {28'd0, dm_req, dm_we, busErr, memStall}, 32'd0);
        chk("midrst_addr", dm_addr, 32'd0);
        chk("midrst_be_wd", dm_wdata | {28'd0, dm_be}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; dm_ack = 1'b1; dm_rdata = 32'h1111_1111;
        @(posedge clk); #1;
        dm_ack = 1'b0;
        chk("postrst_ack", dataMemOut, 32'd0);
        chk("postrst_ctl", {30'd0, dm_req, memStall}, 32'd0);

        // memRead & memWrite together -> write, dataMemOut untouched
        run_access(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 2, 32'h5555_5555,
                   4'b1111, 32'hCAFE_F00D, 32'd0, 1'b0, 3);

        repeat (2) @(posedge clk);
        #1;
        chk("buserr_pulses", berr_cnt, 32'd1);
        chk("req_q_empty", req_q.size(), 32'd0);
        chk("comp_q_empty", comp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
